// File: rtl/numberle_judge.sv
// rtl/numberle_judge.sv - sequential judge for a digit-code guessing game
// Scores one digit per cycle: an exact pass, then a present pass over unmatched secret digits.
module numberle_judge #(
   parameter int DIGITS    = 4,
   parameter int MAX_TRIES = 6
) (
   input  logic                  clock,
   input  logic                  resetn,
   input  logic                  new_game,
   input  logic [DIGITS*4-1:0]   secret,
   input  logic                  guess_valid,
   input  logic [DIGITS*4-1:0]   guess,
   output logic                  guess_ready,
   output logic [DIGITS-1:0]     exact,
   output logic [DIGITS-1:0]     present,
   output logic                  result_valid,
   output logic [3:0]            try_count,
   output logic [3:0]            message,
   output logic                  win,
   output logic                  lose
);

   localparam int             IW       = $clog2(DIGITS);
   localparam logic [IW-1:0]  LAST_IDX = IW'(DIGITS - 1);
   localparam logic [3:0]     MAX_T    = 4'(MAX_TRIES);

   typedef enum logic [2:0] {
      S_IDLE, S_READY, S_EXACT, S_PRESENT, S_REPORT, S_WIN, S_LOSE
   } state_t;

   state_t               state_q, state_d;
   logic [DIGITS*4-1:0]  secret_q, guess_q;
   logic [DIGITS-1:0]    exact_q, present_q, used_q;
   logic [IW-1:0]        idx_q;
   logic [3:0]           try_q;

   logic [3:0]           g_dig, s_dig;
   logic [DIGITS-1:0]    idx_oh, claim;
   logic                 found, exact_hit, present_hit, idx_last;
   logic [3:0]           try_next;

   // Digit under evaluation and the lowest still-unclaimed secret position holding it.
   always_comb begin
      g_dig  = '0;
      s_dig  = '0;
      idx_oh = '0;
      claim  = '0;
      found  = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            g_dig     = guess_q[4*i +: 4];
            s_dig     = secret_q[4*i +: 4];
            idx_oh[i] = 1'b1;
         end
      end
      for (int j = 0; j < DIGITS; j++) begin
         if (!found && !used_q[j] && (secret_q[4*j +: 4] == g_dig)) begin
            claim[j] = 1'b1;
            found    = 1'b1;
         end
      end
      exact_hit   = (g_dig == s_dig);
      present_hit = found && ((exact_q & idx_oh) == '0);
      idx_last    = (idx_q == LAST_IDX);
      try_next    = (try_q == MAX_T) ? try_q : try_q + 4'd1;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    state_d = S_IDLE;
         S_READY:   if (guess_valid) state_d = S_EXACT;
         S_EXACT:   if (idx_last) state_d = S_PRESENT;
         S_PRESENT: if (idx_last) state_d = S_REPORT;
         S_REPORT: begin
            if (&exact_q)            state_d = S_WIN;
            else if (try_q == MAX_T) state_d = S_LOSE;
            else                     state_d = S_READY;
         end
         S_WIN:     state_d = S_WIN;
         S_LOSE:    state_d = S_LOSE;
         default:   state_d = S_IDLE;
      endcase
      if (new_game) state_d = S_READY;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         secret_q  <= '0;
         guess_q   <= '0;
         exact_q   <= '0;
         present_q <= '0;
         used_q    <= '0;
         idx_q     <= '0;
         try_q     <= '0;
      end else if (new_game) begin
         secret_q  <= secret;
         exact_q   <= '0;
         present_q <= '0;
         used_q    <= '0;
         idx_q     <= '0;
         try_q     <= '0;
      end else begin
         unique case (state_q)
            S_READY: begin
               if (guess_valid) begin
                  guess_q   <= guess;
                  exact_q   <= '0;
                  present_q <= '0;
                  used_q    <= '0;
                  idx_q     <= '0;
               end
            end
            S_EXACT: begin
               if (exact_hit) begin
                  exact_q <= exact_q | idx_oh;
                  used_q  <= used_q | idx_oh;
               end
               idx_q <= idx_last ? '0 : idx_q + IW'(1);
            end
            S_PRESENT: begin
               if (present_hit) begin
                  present_q <= present_q | idx_oh;
                  used_q    <= used_q | claim;
               end
               idx_q <= idx_last ? '0 : idx_q + IW'(1);
               // The count moves on the edge that enters REPORT.
               if (idx_last) try_q <= try_next;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      guess_ready  = 1'b0;
      result_valid = 1'b0;
      win          = 1'b0;
      lose         = 1'b0;
      message      = try_q;
      unique case (state_q)
         S_IDLE:   message = 4'h0;
         S_READY:  guess_ready = 1'b1;
         S_REPORT: result_valid = 1'b1;
         S_WIN: begin
            win     = 1'b1;
            message = 4'hA;
         end
         S_LOSE: begin
            lose    = 1'b1;
            message = 4'hE;
         end
         default: ;
      endcase
   end

   assign exact     = exact_q;
   assign present   = present_q;
   assign try_count = try_q;

endmodule

// File: tb/tb_numberle_judge.sv
// tb/tb_numberle_judge.sv - scoreboard bench for numberle_judge
// Stimulus pushes expected scores; a negedge monitor pops them whenever result_valid is seen.
module tb_numberle_judge;

   logic        clock = 1'b0;
   logic        resetn, new_game, guess_valid;
   logic [15:0] secret, guess;
   logic        guess_ready, result_valid, win, lose;
   logic [3:0]  exact, present, try_count, message;

   typedef struct packed {
      logic [3:0] e;
      logic [3:0] p;
      logic [3:0] t;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   numberle_judge #(.DIGITS(4), .MAX_TRIES(6)) dut (
      .clock(clock), .resetn(resetn), .new_game(new_game), .secret(secret),
      .guess_valid(guess_valid), .guess(guess), .guess_ready(guess_ready),
      .exact(exact), .present(present), .result_valid(result_valid),
      .try_count(try_count), .message(message), .win(win), .lose(lose)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (resetn && result_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_result_valid", 32'd1, 32'd0);
         end else begin
            exp_t x;
            x = sb.pop_front();
            chk("result_exact", 32'(exact), 32'(x.e));
            chk("result_present", 32'(present), 32'(x.p));
            chk("result_try_count", 32'(try_count), 32'(x.t));
            chk("result_message", 32'(message), 32'(x.t));
         end
      end
   end

   task automatic start(input logic [15:0] s);
      new_game = 1'b1;
      secret   = s;
      @(posedge clock); #1;
      new_game = 1'b0;
   endtask

   task automatic wait_result();
      int n;
      n = 0;
      while (!result_valid && n < 20) begin
         @(posedge clock); #1;
         n++;
      end
      chk("result_latency", 32'(n), 32'd8);
      @(posedge clock); #1;
   endtask

   task automatic push(input logic [3:0] e, input logic [3:0] p, input logic [3:0] t);
      exp_t x;
      x.e = e; x.p = p; x.t = t;
      sb.push_back(x);
   endtask

   task automatic play(input logic [15:0] g, input logic [3:0] e, input logic [3:0] p, input logic [3:0] t);
      int n;
      n = 0;
      while (!guess_ready && n < 30) begin
         @(posedge clock); #1;
         n++;
      end
      chk("guess_ready_before_play", 32'(guess_ready), 32'd1);
      guess_valid = 1'b1;
      guess       = g;
      push(e, p, t);
      @(posedge clock); #1;
      guess_valid = 1'b0;
      wait_result();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      resetn = 1'b0; new_game = 1'b0; guess_valid = 1'b0;
      secret = '0; guess = '0;
      #3;
      chk("reset_outputs", 32'({guess_ready, exact, present, result_valid, try_count, message, win, lose}), 32'd0);
      @(posedge clock); #1;
      resetn = 1'b1;
      @(posedge clock); #1;
      chk("idle_guess_ready", 32'(guess_ready), 32'd0);
      chk("idle_message", 32'(message), 32'd0);

      // Win on first try, with guess_valid left high through REPORT and WIN.
      start(16'h1234);
      chk("ready_after_new_game", 32'(guess_ready), 32'd1);
      chk("ready_try_count", 32'(try_count), 32'd0);
      guess_valid = 1'b1;
      guess       = 16'h1234;
      push(4'b1111, 4'b0000, 4'd1);
      @(posedge clock); #1;
      guess = 16'h5555;
      wait_result();
      chk("win_flag", 32'(win), 32'd1);
      chk("win_message", 32'(message), 32'hA);
      repeat (3) begin @(posedge clock); #1; end
      chk("win_hold_exact", 32'(exact), 32'hF);
      chk("win_hold_present", 32'(present), 32'd0);
      chk("win_hold_try", 32'(try_count), 32'd1);
      chk("win_hold_ready", 32'(guess_ready), 32'd0);
      chk("win_hold_flag", 32'(win), 32'd1);
      guess_valid = 1'b0;

      // Duplicate digits, then hex digits with no overlap.
      start(16'h1123);
      play(16'h3111, 4'b0100, 4'b1001, 4'd1);
      play(16'hABCD, 4'b0000, 4'b0000, 4'd2);
      chk("ready_after_report", 32'(guess_ready), 32'd1);
      chk("ready_message", 32'(message), 32'd2);

      start(16'hFA0F);
      play(16'hF0AF, 4'b1001, 4'b0110, 4'd1);

      // new_game during PRESENT beats a simultaneous guess.
      start(16'h1234);
      guess_valid = 1'b1;
      guess       = 16'h5678;
      @(posedge clock); #1;
      guess_valid = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      new_game = 1'b1; secret = 16'h1234;
      guess_valid = 1'b1; guess = 16'h1234;
      @(posedge clock); #1;
      new_game = 1'b0; guess_valid = 1'b0;
      chk("abort_ready", 32'(guess_ready), 32'd1);
      chk("abort_try", 32'(try_count), 32'd0);
      chk("abort_exact", 32'(exact), 32'd0);
      @(posedge clock); #1;
      chk("abort_guess_not_taken", 32'(guess_ready), 32'd1);
      repeat (12) begin @(posedge clock); #1; end
      chk("abort_try_later", 32'(try_count), 32'd0);

      // Six misses lose the game.
      start(16'h1234);
      for (int t = 1; t <= 6; t++) play(16'h9999, 4'b0000, 4'b0000, 4'(t));
      chk("lose_flag", 32'(lose), 32'd1);
      chk("lose_message", 32'(message), 32'hE);
      chk("lose_ready", 32'(guess_ready), 32'd0);
      chk("lose_try", 32'(try_count), 32'd6);
      chk("lose_win_low", 32'(win), 32'd0);

      // Reset in the middle of EXACT aborts without a result.
      start(16'h1234);
      guess_valid = 1'b1;
      guess       = 16'h1234;
      @(posedge clock); #1;
      guess_valid = 1'b0;
      @(posedge clock); #3;
      resetn = 1'b0;
      #1;
      chk("midexact_reset_outputs", 32'({guess_ready, exact, present, result_valid, try_count, message, win, lose}), 32'd0);
      @(posedge clock); #1;
      resetn = 1'b1;
      repeat (12) begin @(posedge clock); #1; end
      chk("post_reset_ready", 32'(guess_ready), 32'd0);
      chk("post_reset_message", 32'(message), 32'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/numberle_judge.md
NUMBERLE_JUDGE -- requirements
Module: numberle_judge

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of 4-bit digits per code (range 2..8).
REQ-002 SHALL have parameter MAX_TRIES, default 6, number of guesses allowed per game (range 1..15).
REQ-003 SHALL have port clock  input  1  sole clock; all flops rise-edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port new_game  input  1  one-cycle strobe; loads secret and starts a game.
REQ-006 SHALL have port secret  input  DIGITS*4  code to guess; digit i = bits [4i+3:4i].
REQ-007 SHALL have port guess_valid  input  1  guess offered.
REQ-008 SHALL have port guess  input  DIGITS*4  guess code, same digit packing.
REQ-009 SHALL have port guess_ready  output  1  high only in state READY.
REQ-010 SHALL have port exact  output  DIGITS  bit i = guess digit i equals secret digit i.
REQ-011 SHALL have port present  output  DIGITS  bit i = guess digit i occurs at another unmatched secret position.
REQ-012 SHALL have port result_valid  output  1  one-cycle pulse; exact/present/try_count valid.
REQ-013 SHALL have port try_count  output  4  guesses judged in current game.
REQ-014 SHALL have port message  output  4  display code for the seven-segment driver.
REQ-015 SHALL have ports win and lose  output  1 each  game-over flags.

Function
REQ-016 SHALL implement states IDLE, READY, EXACT, PRESENT, REPORT, WIN, LOSE.
REQ-017 SHALL register secret into an internal copy on new_game in any state, clear try_count/exact/present/win/lose, and enter READY next edge.
REQ-018 SHALL give new_game priority over a simultaneous guess_valid; that guess is not accepted and not counted.
REQ-019 SHALL accept a guess on an edge where guess_valid && guess_ready; register guess, clear exact, present and internal used mask, enter EXACT with index 0.
REQ-020 SHALL in EXACT evaluate one digit per cycle (index 0..DIGITS-1): set exact[i] and used[i] if guess[i]==secret[i]; leave to PRESENT after DIGITS cycles.
REQ-021 SHALL in PRESENT evaluate one guess digit per cycle: if exact[i]==0, find lowest j with used[j]==0 and secret[j]==guess[i]; if found set present[i] and used[j].
REQ-022 SHALL thereby count duplicates correctly: each secret digit credits at most one exact or present bit.
REQ-023 SHALL compare all 4-bit values literally, including 4'hA..4'hF.
REQ-024 SHALL enter REPORT after DIGITS PRESENT cycles, i.e. on edge k+2*DIGITS for accept edge k; REPORT lasts exactly one cycle.
REQ-025 SHALL increment try_count on entry to REPORT, saturating at MAX_TRIES.
REQ-026 SHALL assert result_valid only while in REPORT; message = try_count there.
REQ-027 SHALL leave REPORT to WIN if exact is all ones, else to LOSE if try_count==MAX_TRIES, else to READY.
REQ-028 SHALL in WIN drive win=1, message=4'hA; in LOSE drive lose=1, message=4'hE; both held until new_game.
REQ-029 SHALL hold exact, present and try_count stable from REPORT until the next accept or new_game.
REQ-030 SHALL drive message=4'h0 in IDLE; in READY, EXACT, PRESENT message holds try_count.
REQ-031 SHALL ignore guess_valid outside READY (no buffering, no error).
REQ-032 SHALL have no combinational path from guess_valid or new_game to any output.

Reset
REQ-033 SHALL on resetn low, immediately and asynchronously: state IDLE, all outputs 0, internal secret, guess, used mask and index 0.
REQ-034 SHALL abort any in-progress judgement on reset with no result_valid produced; release is synchronous to clock.

Verification
REQ-035 Reset: assert resetn=0 mid-EXACT -> all outputs 0 immediately, guess_ready 0 after release until new_game.
REQ-036 DIGITS=4, secret 16'h1234, guess 16'h1234 at edge k -> result_valid cycle after edge k+8, exact=4'b1111, present=0, try_count=1, message=1; next cycle win=1, message=4'hA.
REQ-037 Duplicates: secret 16'h1123, guess 16'h3111 -> exact=4'b0100, present=4'b1001.
REQ-038 Loss: six guesses all 16'h9999 vs secret 16'h1234 -> try_count 1..6, present=0, after 6th lose=1, message=4'hE, guess_ready=0.
REQ-039 new_game asserted in PRESENT with guess_valid high -> no result_valid, READY next cycle, try_count=0, guess not accepted.
REQ-040 guess_valid held high in REPORT and WIN -> not accepted; exact/present unchanged.
